// File: rtl/board_scan_driver_if.sv
// Signal bundle between the game logic and the LED matrix scan driver.
// The master drives board state and cursor; the slave drives the matrix pins.
interface board_scan_driver_if;
  logic [41:0] p1_cells;
  logic [41:0] p2_cells;
  logic [2:0]  cursor_col;
  logic        cursor_player;
  logic        win_flash;
  logic [5:0]  row_sel;
  logic [6:0]  col_red;
  logic [6:0]  col_yel;
  logic        frame_start;
  logic        conflict;

  modport master (
    output p1_cells, p2_cells, cursor_col, cursor_player, win_flash,
    input  row_sel, col_red, col_yel, frame_start, conflict
  );

  modport slave (
    input  p1_cells, p2_cells, cursor_col, cursor_player, win_flash,
    output row_sel, col_red, col_yel, frame_start, conflict
  );
endinterface

// File: rtl/board_scan_driver.sv
// Row-scanned driver for the 6x7 bicolour Connect-4 LED matrix with
// per-slot blanking, a blinking drop cursor and a whole-board win flash.
module board_scan_driver #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK        = 16,
  parameter int BLINK_FRAMES = 32
) (
  input logic               clk,
  input logic               rst_n,
  board_scan_driver_if.slave scan
);

  localparam logic [15:0] SLOT_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] BLANK_W    = 16'(BLANK);
  localparam logic [7:0]  FRAME_LAST = 8'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DRIVE} state_e;

  state_e      state_q, state_d;
  logic [15:0] slot_q, slot_d;
  logic [2:0]  row_q, row_d;
  logic [7:0]  frame_q, frame_d;
  logic        blinkOn_q, blinkOn_d;
  logic [41:0] snapP1_q, snapP1_d;
  logic [41:0] snapP2_q, snapP2_d;
  logic        conflict_q, conflict_d;
  logic        frameStart_q, frameStart_d;
  logic [5:0]  rowSel_q, rowSel_d;
  logic [6:0]  colRed_q, colRed_d;
  logic [6:0]  colYel_q, colYel_d;

  logic [5:0]  rowBase;
  logic [6:0]  rowP1, rowP2, topOcc, cursorMask, red, yel;
  logic        cursorOn;

  // Every output is registered from the position the counters step into.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      row_q        <= '0;
      frame_q      <= '0;
      blinkOn_q    <= 1'b1;
      snapP1_q     <= '0;
      snapP2_q     <= '0;
      conflict_q   <= 1'b0;
      frameStart_q <= 1'b0;
      rowSel_q     <= '0;
      colRed_q     <= '0;
      colYel_q     <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      row_q        <= row_d;
      frame_q      <= frame_d;
      blinkOn_q    <= blinkOn_d;
      snapP1_q     <= snapP1_d;
      snapP2_q     <= snapP2_d;
      conflict_q   <= conflict_d;
      frameStart_q <= frameStart_d;
      rowSel_q     <= rowSel_d;
      colRed_q     <= colRed_d;
      colYel_q     <= colYel_d;
    end
  end

  // The very first frame after reset does not advance the blink counter.
  always_comb begin
    slot_d    = slot_q;
    row_d     = row_q;
    frame_d   = frame_q;
    blinkOn_d = blinkOn_q;
    if (state_q == ST_IDLE) begin
      slot_d = '0;
      row_d  = '0;
    end else if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      row_d  = (row_q == 3'd5) ? 3'd0 : row_q + 3'd1;
    end else begin
      slot_d = slot_q + 16'd1;
    end
    frameStart_d = (slot_d == 16'd0) && (row_d == 3'd0);
    if (frameStart_d && (state_q != ST_IDLE)) begin
      if (frame_q == FRAME_LAST) begin
        frame_d   = '0;
        blinkOn_d = ~blinkOn_q;
      end else begin
        frame_d = frame_q + 8'd1;
      end
    end
    snapP1_d   = frameStart_d ? scan.p1_cells : snapP1_q;
    snapP2_d   = frameStart_d ? scan.p2_cells : snapP2_q;
    conflict_d = conflict_q | (frameStart_d && ((scan.p1_cells & scan.p2_cells) != 42'd0));
    state_d    = (slot_d < BLANK_W) ? ST_BLANK : ST_DRIVE;
  end

  // A doubly-claimed cell shows red only; the cursor needs an empty top cell.
  always_comb begin
    rowBase    = 6'(row_d) * 6'd7;
    rowP1      = snapP1_d[rowBase +: 7];
    rowP2      = snapP2_d[rowBase +: 7];
    topOcc     = snapP1_d[41:35] | snapP2_d[41:35];
    cursorMask = (scan.cursor_col <= 3'd6) ? (7'b1 << scan.cursor_col) : 7'b0;
    cursorOn   = blinkOn_d && (row_d == 3'd5) && (cursorMask != 7'd0)
                 && ((cursorMask & topOcc) == 7'd0);
    red = rowP1;
    yel = rowP2 & ~rowP1;
    if (cursorOn) begin
      if (scan.cursor_player) yel = yel | cursorMask;
      else                    red = red | cursorMask;
    end
    if (scan.win_flash && !blinkOn_d) begin
      red = '0;
      yel = '0;
    end
    rowSel_d = 6'b1 << row_d;
    colRed_d = (state_d == ST_DRIVE) ? red : 7'd0;
    colYel_d = (state_d == ST_DRIVE) ? yel : 7'd0;
  end

  assign scan.row_sel     = rowSel_q;
  assign scan.col_red     = colRed_q;
  assign scan.col_yel     = colYel_q;
  assign scan.frame_start = frameStart_q;
  assign scan.conflict    = conflict_q;

endmodule

// File: tb/tb_board_scan_driver.sv
// Directed self-checking bench for board_scan_driver with an 8-cycle row slot,
// 2 blanking cycles and a 2-frame blink half-period (48-cycle frames).
module tb_board_scan_driver;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  board_scan_driver_if scanIf();

  board_scan_driver #(
    .CLK_DIV(8),
    .BLANK(2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .scan (scanIf.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) step();
  endtask

  task automatic applyStimulus(input logic [41:0] p1, input logic [41:0] p2,
                               input logic [2:0] col, input logic player,
                               input logic win);
    scanIf.p1_cells      = p1;
    scanIf.p2_cells      = p2;
    scanIf.cursor_col    = col;
    scanIf.cursor_player = player;
    scanIf.win_flash     = win;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the first clock edge after rst_n rises, observed at its negedge.
  task automatic resetAndRelease();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(42'd0, 42'd0, 3'd7, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rstRowSel", scanIf.row_sel, 6'd0);
    checkOutput("rstRed", scanIf.col_red, 7'd0);
    checkOutput("rstYel", scanIf.col_yel, 7'd0);
    checkOutput("rstFs", scanIf.frame_start, 1'b0);
    checkOutput("rstConflict", scanIf.conflict, 1'b0);

    // Empty board: plain row scan and frame pulses.
    resetAndRelease();
    for (int c = 0; c <= 48; c++) begin
      stepTo(c);
      checkOutput("scanRowSel", scanIf.row_sel, 64'(6'b1 << ((c / 8) % 6)));
      checkOutput("scanFs", scanIf.frame_start, 64'((c % 48) == 0));
      checkOutput("scanRed", scanIf.col_red, 7'd0);
      checkOutput("scanYel", scanIf.col_yel, 7'd0);
    end

    // p1 bit 0 and p2 bit 8, blanking in slots 0..1.
    applyStimulus(42'd1, 42'd1 << 8, 3'd7, 1'b0, 1'b0);
    resetAndRelease();
    for (int c = 0; c < 16; c++) begin
      stepTo(c);
      checkOutput("row0Red", scanIf.col_red, (c >= 2 && c <= 7) ? 64'd1 : 64'd0);
      checkOutput("row1Yel", scanIf.col_yel, (c >= 10) ? 64'd2 : 64'd0);
    end
    stepTo(26);
    applyStimulus(42'd1 << 29, 42'd1 << 8, 3'd7, 1'b0, 1'b0);
    stepTo(36);
    checkOutput("tearOldRow4", scanIf.col_red, 7'd0);
    stepTo(50);
    checkOutput("tearNewRow0", scanIf.col_red, 7'd0);
    stepTo(58);
    checkOutput("tearRow1Yel", scanIf.col_yel, 7'b0000010);
    stepTo(84);
    checkOutput("tearNewRow4", scanIf.col_red, 7'b0000010);

    // Yellow cursor on column 3 blinking every two frames.
    applyStimulus(42'd0, 42'd0, 3'd3, 1'b1, 1'b0);
    resetAndRelease();
    for (int f = 0; f < 5; f++) begin
      stepTo(48 * f + 40);
      checkOutput("cursorBlankYel", scanIf.col_yel, 7'd0);
      stepTo(48 * f + 44);
      checkOutput("cursorYel", scanIf.col_yel, ((f % 4) < 2) ? 64'h8 : 64'h0);
      checkOutput("cursorRed", scanIf.col_red, 7'd0);
    end
    stepTo(238);
    applyStimulus(42'd1 << 38, 42'd0, 3'd3, 1'b1, 1'b0);
    stepTo(284);
    checkOutput("fullColRed", scanIf.col_red, 7'b0001000);
    checkOutput("fullColYel", scanIf.col_yel, 7'd0);
    stepTo(332);
    checkOutput("fullColRedOff", scanIf.col_red, 7'b0001000);
    checkOutput("fullColYelOff", scanIf.col_yel, 7'd0);

    // Both players on bit 10: sticky conflict, red-only display.
    applyStimulus(42'd1 << 10, 42'd1 << 10, 3'd7, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("conflictPre", scanIf.conflict, 1'b0);
    resetAndRelease();
    checkOutput("conflictSet", scanIf.conflict, 1'b1);
    stepTo(12);
    checkOutput("conflictRed", scanIf.col_red, 7'b0001000);
    checkOutput("conflictYel", scanIf.col_yel, 7'd0);
    stepTo(20);
    applyStimulus(42'd0, 42'd0, 3'd7, 1'b0, 1'b0);
    stepTo(60);
    checkOutput("conflictClrRed", scanIf.col_red, 7'd0);
    checkOutput("conflictSticky", scanIf.conflict, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("conflictRst", scanIf.conflict, 1'b0);

    // Win flash with p1 bit 0 and a red cursor on column 3.
    applyStimulus(42'd1, 42'd0, 3'd3, 1'b0, 1'b1);
    resetAndRelease();
    for (int f = 0; f < 5; f++) begin
      stepTo(48 * f + 4);
      checkOutput("winRow0Red", scanIf.col_red, ((f % 4) < 2) ? 64'h1 : 64'h0);
      stepTo(48 * f + 20);
      checkOutput("winRowSel", scanIf.row_sel, 6'b000100);
      stepTo(48 * f + 44);
      checkOutput("winCursorRed", scanIf.col_red, ((f % 4) < 2) ? 64'h8 : 64'h0);
    end
    stepTo(244);
    checkOutput("preAsyncRed", scanIf.col_red, 7'b0000001);
    checkOutput("preAsyncRowSel", scanIf.row_sel, 6'b000001);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRowSel", scanIf.row_sel, 6'd0);
    checkOutput("asyncRed", scanIf.col_red, 7'd0);
    checkOutput("asyncYel", scanIf.col_yel, 7'd0);
    checkOutput("asyncFs", scanIf.frame_start, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
